// File: rtl/fetch_decode_pkg.sv
// Shared types and constants for the fetch/decode stage: FSM states, opcodes,
// instruction field positions and the decoded-field record.
`timescale 1ns/1ps
package fetch_decode_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_DRAIN  = 2'd3
    } fd_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int OPC_LSB   = 26;
    localparam int OPC_W     = 6;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int REG_W     = 5;
    localparam int FUNCT_LSB = 0;
    localparam int FUNCT_W   = 6;
    localparam int IMM_W     = 16;

    localparam logic [31:0] FD_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  reg_s;
        logic [4:0]  reg_t;
        logic [4:0]  reg_d;
        logic        reg_write;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/fetch_decode_if.sv
// Instruction-memory, redirect/stall and decoded-output signals of fetch_decode.
// master = the fetch/decode stage, slave = memory plus downstream consumer.
`timescale 1ns/1ps
interface fetch_decode_if;

    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        valid;
    logic [31:0] pcOut;
    logic [4:0]  regS;
    logic [4:0]  regT;
    logic [4:0]  regD;
    logic        regWrite;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic        illegal;

    modport master (
        output imemReq, imemAddr, valid, pcOut, regS, regT, regD,
               regWrite, opcode, funct, imm, illegal,
        input  imemAck, imemData, stall, branchTaken, branchTarget
    );

    modport slave (
        input  imemReq, imemAddr, valid, pcOut, regS, regT, regD,
               regWrite, opcode, funct, imm, illegal,
        output imemAck, imemData, stall, branchTaken, branchTarget
    );

endinterface

// File: rtl/fetch_decode_instr_decoder.sv
// Combinational instruction word -> register selects / immediate / regWrite.
// FD_ILLEGAL_TRAP_EN flags selects beyond the 16-entry bank and suppresses the write.
`timescale 1ns/1ps
module instr_decoder
    import fetch_decode_pkg::*;
(
    input  logic [31:0] word,
    output dec_t        dec
);

    logic [5:0] opc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       wr;

    always_comb begin
        opc = word[OPC_LSB +: OPC_W];
        rs  = word[RS_LSB +: REG_W];
        rt  = word[RT_LSB +: REG_W];
        rd  = (opc == OP_RTYPE) ? word[RD_LSB +: REG_W] : rt;
        // writes to r0 are dropped so the bank never sees a pointless enable
        wr  = (opc != OP_SW) && (opc != OP_BEQ) && (rd != 5'd0);

        dec        = '0;
        dec.opcode = opc;
        dec.reg_s  = rs;
        dec.reg_t  = rt;
        dec.reg_d  = rd;
        dec.funct  = word[FUNCT_LSB +: FUNCT_W];
        dec.imm    = {{(32-IMM_W){word[IMM_W-1]}}, word[IMM_W-1:0]};
`ifdef FD_ILLEGAL_TRAP_EN
        dec.illegal   = rs[4] | rt[4] | (wr & rd[4]);
        dec.reg_write = wr & ~dec.illegal;
`else
        dec.illegal   = 1'b0;
        dec.reg_write = wr;
`endif
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC + imem handshake FSM, registered decoded outputs.
// Optional FD_ILLEGAL_TRAP_EN is handled inside instr_decoder.
`timescale 1ns/1ps
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FD_RESET_PC
) (
    input logic            clk,
    input logic            reset,
    fetch_decode_if.master bus
);

    fd_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    dec_t        out_q, out_d;
    dec_t        dec;
    logic [31:0] tgt;

    instr_decoder u_dec (
        .word (bus.imemData),
        .dec  (dec)
    );

    assign tgt = bus.branchTarget & ~32'h3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            valid_q      <= 1'b0;
            pc_out_q     <= RESET_PC;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            valid_q      <= valid_d;
            pc_out_q     <= pc_out_d;
            out_q        <= out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        valid_d      = valid_q;
        pc_out_d     = pc_out_q;
        out_d        = out_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.branchTaken) begin
                    pc_d = tgt;
                    // an unanswered request must still be drained at its old address
                    if (!bus.imemAck) begin
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end else if (bus.imemAck) begin
                    out_d    = dec;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.branchTaken) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!bus.stall) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (bus.branchTaken) pc_d = tgt;
                if (bus.imemAck) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imemReq  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign bus.imemAddr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign bus.valid    = valid_q;
    assign bus.pcOut    = pc_out_q;
    assign bus.regS     = out_q.reg_s;
    assign bus.regT     = out_q.reg_t;
    assign bus.regD     = out_q.reg_d;
    assign bus.regWrite = out_q.reg_write;
    assign bus.opcode   = out_q.opcode;
    assign bus.funct    = out_q.funct;
    assign bus.imm      = out_q.imm;
    assign bus.illegal  = out_q.illegal;

endmodule
